// File: rtl/seq_csa_multiplier.sv
// seq_csa_multiplier: multi-cycle signed/unsigned integer multiplier.
// Each ACCUM cycle folds PP_PER_CYCLE partial products into a registered
// carry-save (sum, carry) pair. A single carry-propagate add in FINAL
// resolves the pair into the 2*WIDTH-bit product.
module seq_csa_multiplier #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned PP_PER_CYCLE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);

  localparam int unsigned N_ITER = WIDTH / PP_PER_CYCLE;
  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;

  // Multiplicand pre-shifted by k*PP_PER_CYCLE, multiplier pre-shifted right
  // by the same amount, so iteration k always uses bit j / shift j locally.
  logic [PW-1:0]     a_shift;
  logic [WIDTH-1:0]  b_shift;
  logic              sign_mode;
  logic [PW-1:0]     sum_q;
  logic [PW-1:0]     carry_q;
  logic [CNT_W-1:0]  cnt;

  logic [PW-1:0]     sum_next;
  logic [PW-1:0]     carry_next;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     sum_t;
  logic [PW-1:0]     maj_t;
  logic              last_iter;

  assign last_iter = (cnt == LAST_ITER);

  // Carry-save reduction of this cycle's slice: a cascade of 3:2 counters,
  // each folding one partial product into the running (sum, carry) pair.
  // In signed mode the multiplier MSB has negative weight, so its partial
  // product enters inverted; the matching +1 is the carry-in of the final add.
  always_comb begin
    sum_next   = sum_q;
    carry_next = carry_q;
    pp         = '0;
    sum_t      = '0;
    maj_t      = '0;
    for (int unsigned j = 0; j < PP_PER_CYCLE; j++) begin
      pp = b_shift[j] ? (a_shift << j) : '0;
      if (sign_mode && last_iter && (j == PP_PER_CYCLE - 1)) begin
        pp = ~pp;
      end
      sum_t      = sum_next ^ carry_next ^ pp;
      maj_t      = (sum_next & carry_next) | (sum_next & pp) | (carry_next & pp);
      sum_next   = sum_t;
      carry_next = maj_t << 1;
    end
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out_product <= '0;
      a_shift     <= '0;
      b_shift     <= '0;
      sign_mode   <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_shift   <= in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a}
                                   : {{WIDTH{1'b0}}, in_a};
            b_shift   <= in_b;
            sign_mode <= in_signed;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          sum_q   <= sum_next;
          carry_q <= carry_next;
          a_shift <= a_shift << PP_PER_CYCLE;
          b_shift <= b_shift >> PP_PER_CYCLE;
          cnt     <= cnt + 1'b1;
          if (last_iter) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          out_product <= sum_q + carry_q + PW'(sign_mode);
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_csa_multiplier.sv
// Self-checking bench for seq_csa_multiplier: directed corners on a 64-bit
// instance, latency/sweep on three 8-bit instances, and a scoreboarded
// random back-to-back regression with random backpressure.
module tb_seq_csa_multiplier;

  localparam int unsigned W  = 64;
  localparam int unsigned SW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [W-1:0]     in_a, in_b;
  logic [2*W-1:0]   out_product;

  int checks   = 0;
  int failures = 0;

  seq_csa_multiplier #(.WIDTH(W), .PP_PER_CYCLE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .busy(busy)
  );

  logic            s_in_valid [3];
  logic            s_in_ready [3];
  logic            s_in_signed[3];
  logic            s_out_valid[3];
  logic            s_out_ready[3];
  logic            s_busy     [3];
  logic [SW-1:0]   s_in_a     [3];
  logic [SW-1:0]   s_in_b     [3];
  logic [2*SW-1:0] s_out_product[3];

  for (genvar g = 0; g < 3; g++) begin : g_small
    localparam int unsigned PP = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    seq_csa_multiplier #(.WIDTH(SW), .PP_PER_CYCLE(PP)) u_small (
      .clk(clk), .rst(rst), .in_valid(s_in_valid[g]), .in_ready(s_in_ready[g]),
      .in_a(s_in_a[g]), .in_b(s_in_b[g]), .in_signed(s_in_signed[g]),
      .out_valid(s_out_valid[g]), .out_ready(s_out_ready[g]),
      .out_product(s_out_product[g]), .busy(s_busy[g])
    );
  end

  function automatic logic [127:0] ref64(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [127:0] ea, eb;
    ea = s ? {{64{a[63]}}, a} : {64'b0, a};
    eb = s ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'b0, a};
    eb = s ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  // One transaction on the 64-bit instance: accept, count edges to out_valid,
  // capture the product, then complete the result handshake.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        output logic [127:0] p, output int lat);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_signed = ~s;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    p = out_product;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op_s(input int k, input logic [7:0] a, input logic [7:0] b, input logic s,
                          output logic [15:0] p, output int lat);
    s_in_a[k] = a; s_in_b[k] = b; s_in_signed[k] = s; s_in_valid[k] = 1'b1; s_out_ready[k] = 1'b0;
    @(posedge clk); #1;
    s_in_valid[k] = 1'b0; s_in_a[k] = ~a; s_in_b[k] = ~b;
    lat = 0;
    while (!s_out_valid[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    p = s_out_product[k];
    s_out_ready[k] = 1'b1;
    @(posedge clk); #1;
    s_out_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_in_valid[k] = 1'b0; s_out_ready[k] = 1'b0; s_in_a[k] = '0; s_in_b[k] = '0; s_in_signed[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_product !== 128'd0) begin failures++; $display("FAIL reset_product got=%0h exp=0", out_product); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (s_in_ready[k] !== 1'b1 || s_out_valid[k] !== 1'b0 || s_busy[k] !== 1'b0) begin
        failures++; $display("FAIL reset_small%0d got=%b%b%b exp=100", k, s_in_ready[k], s_out_valid[k], s_busy[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_max;
    logic [127:0] p;
    int lat;
    run_op('1, '1, 1'b0, p, lat);
    checks++; if (p !== 128'hFFFFFFFFFFFFFFFE0000000000000001) begin failures++; $display("FAIL umax_product got=%0h exp=fffffffffffffffe0000000000000001", p); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL umax_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_signed_corners;
    logic [63:0]  ta[5];
    logic [63:0]  tb[5];
    logic         ts[5];
    logic [127:0] te[5];
    logic [127:0] p;
    int lat;
    ta = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFD, 64'h8000000000000000, 64'h8000000000000000, 64'h8000000000000000};
    tb = '{64'hFFFFFFFFFFFFFFFF, 64'd5, 64'h8000000000000000, 64'd1, 64'd1};
    ts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    te = '{128'd1,
           128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF1,
           128'h40000000000000000000000000000000,
           128'hFFFFFFFFFFFFFFFF8000000000000000,
           128'h00000000000000008000000000000000};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], ts[i], p, lat);
      checks++; if (p !== te[i]) begin failures++; $display("FAIL corner%0d_product got=%0h exp=%0h", i, p, te[i]); end
      checks++; if (lat !== 9) begin failures++; $display("FAIL corner%0d_latency got=%0d exp=9", i, lat); end
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] held;
    int n;
    in_a = 64'd123456789; in_b = 64'd987654321; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    held = out_product;
    checks++; if (held !== 128'd121932631112635269) begin failures++; $display("FAIL bp_product got=%0h exp=%0h", held, 128'd121932631112635269); end
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 5);
      in_a = 64'd5; in_b = 64'd5;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold got=%b exp=1", out_valid); end
      checks++; if (out_product !== held) begin failures++; $display("FAIL bp_product_stable got=%0h exp=%0h", out_product, held); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_capture got=%b exp=0", busy); end
  endtask

  task automatic test_issue_interval;
    int acc[3];
    int na, cyc;
    in_a = 64'd3; in_b = 64'd4; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    na = 0; cyc = 0;
    while (na < 3 && cyc < 60) begin
      if (in_valid && in_ready) begin acc[na] = cyc; na++; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (na !== 3) begin failures++; $display("FAIL issue_accepts got=%0d exp=3", na); end
    else begin
      checks++; if (acc[1] - acc[0] !== 11) begin failures++; $display("FAIL issue_interval1 got=%0d exp=11", acc[1] - acc[0]); end
      checks++; if (acc[2] - acc[1] !== 11) begin failures++; $display("FAIL issue_interval2 got=%0d exp=11", acc[2] - acc[1]); end
    end
    cyc = 0;
    while (busy && cyc < 40) begin @(posedge clk); #1; cyc++; end
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL issue_drain got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] p;
    int lat;
    in_a = 64'h1234; in_b = 64'h5678; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (out_product !== 128'd0) begin failures++; $display("FAIL rmid_product got=%0h exp=0", out_product); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rmid_after got=%b%b exp=10", in_ready, out_valid); end
    run_op(64'd7, 64'd6, 1'b0, p, lat);
    checks++; if (p !== 128'd42) begin failures++; $display("FAIL rmid_7x6 got=%0d exp=42", p); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL rmid_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_sweep(input int k);
    logic [7:0]  edges[6];
    logic [15:0] p, e;
    logic [7:0]  a, b;
    logic        s;
    int lat, exp_lat;
    edges = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};
    exp_lat = (k == 0) ? 9 : ((k == 1) ? 5 : 2);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          s = (m == 1);
          run_op_s(k, edges[i], edges[j], s, p, lat);
          e = ref8(edges[i], edges[j], s);
          checks++; if (p !== e) begin failures++; $display("FAIL sweep%0d_edge s=%b a=%0h b=%0h got=%0h exp=%0h", k, s, edges[i], edges[j], p, e); end
          checks++; if (lat !== exp_lat) begin failures++; $display("FAIL sweep%0d_latency got=%0d exp=%0d", k, lat, exp_lat); end
        end
      end
    end
    for (int r = 0; r < 60; r++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      run_op_s(k, a, b, s, p, lat);
      e = ref8(a, b, s);
      checks++; if (p !== e) begin failures++; $display("FAIL sweep%0d_rand s=%b a=%0h b=%0h got=%0h exp=%0h", k, s, a, b, p, e); end
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 1200;
    logic [127:0] sb[$];
    logic [127:0] e;
    int sent, recv, cyc, pick;
    bit accepted;
    sent = 0; recv = 0; cyc = 0; accepted = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (recv < N && cyc < 40000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL b2b_extra_result got=%0h exp=none", out_product);
        end else begin
          e = sb.pop_front();
          if (out_product !== e) begin failures++; $display("FAIL b2b_product n=%0d got=%0h exp=%0h", recv, out_product, e); end
        end
        recv++;
      end
      if (!in_valid && sent < N) begin
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_signed = 1'($urandom);
        pick = $urandom_range(0, 15);
        if (pick == 0) in_a = 64'h8000000000000000;
        if (pick == 1) in_b = '1;
        if (pick == 2) in_a = '0;
        in_valid = 1'b1;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref64(in_a, in_b, in_signed));
        sent++;
        accepted = 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin in_valid = 1'b0; accepted = 0; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (recv !== N) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", recv, N); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_backpressure();
    test_issue_interval();
    test_reset_mid();
    for (int k = 0; k < 3; k++) test_sweep(k);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_csa_multiplier.md
# seq_csa_multiplier

Multi-cycle parametrised integer multiplier for the execution units. Each cycle it reduces a slice of PP_PER_CYCLE partial products into a registered carry-save (sum, carry) accumulator with a CSA tree, then does one full-width carry-propagate add. It supports signed and unsigned operands. A valid/ready handshake on both sides lets the issue logic stall it and lets writeback apply backpressure.

## Interface
- WIDTH, 64: operand width. Must be ≥ 4.
- PP_PER_CYCLE, 8: partial products reduced per accumulation cycle. Must be ≥ 1 and divide WIDTH.
- Derived N_ITER = WIDTH / PP_PER_CYCLE.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept an operand.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- out_valid  out  1  out_product holds a finished result.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2*WIDTH  full-width product.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, FINAL, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready, register in_a, in_b and in_signed.
  - Clear the sum and carry registers (2*WIDTH bits each) and the iteration counter.
  - Move to ACCUM.
- **ACCUM**
  - Iteration k compresses partial products k*P .. k*P+P-1 (P = PP_PER_CYCLE) together with sum and carry into a new sum/carry pair, through a 3:2 CSA tree.
  - Partial product i = b[i] ? (A_ext << i) : 0.
  - A_ext is in_a zero-extended to 2*WIDTH bits, or sign-extended when in_signed.
  - Signed mode, i = WIDTH-1: the partial product is subtracted. Add its bitwise inverse (2*WIDTH bits) and inject +1. The +1 may be applied as the carry-in of the final add.
  - Counter increments each cycle. After iteration N_ITER-1, move to FINAL.
- **FINAL**
  - One 2*WIDTH-bit carry-propagate add of sum + carry + correction.
  - Result is registered into out_product.
  - Move to DONE.
- **DONE**
  - out_valid = 1; out_product held stable.
  - On out_valid & out_ready, move to IDLE.
- Arithmetic is modulo 2^(2*WIDTH) and must be exact:
  - unsigned: a*b in [0, (2^W−1)^2];
  - signed: full two's-complement product, including min*min = 2^(2W−2).
- All carries out of bit 2*WIDTH−1 are discarded.
- in_valid while busy: ignored, not captured. in_ready = 0 outside IDLE.
- Operand inputs are sampled only at the accept edge; later changes have no effect.
- in_ready must not depend combinationally on out_ready.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, out_product 0; sum, carry and counter all 0.
- Reset asserted mid-operation: abort immediately, with all outputs at their reset values; the in-flight result is lost.
- Accept edge T0 → out_valid rises after edge T0+N_ITER+1. With defaults that is a latency of 9 cycles.
- Result handshake at edge X → in_ready = 1 in the cycle after X; next accept no earlier than edge X+1.
- With out_ready tied high, the minimum issue interval is N_ITER+3 cycles (11 at defaults).
- out_ready low: remain in DONE indefinitely, out_product unchanged, in_ready 0.
- PP_PER_CYCLE = WIDTH: N_ITER = 1, latency 2.
- out_product changes only at the FINAL→DONE edge and on reset.

## Test plan
- **Unsigned max:** WIDTH=64, a = b = 0xFFFF_FFFF_FFFF_FFFF, in_signed=0 → 0xFFFFFFFFFFFFFFFE_0000000000000001; out_valid on the 9th edge after accept.
- **Signed corners:** in_signed=1.
  - −1 × −1 → 1.
  - −3 × 5 → 0xFFFF…FFF1 (128 bits).
  - 0x8000…0 × 0x8000…0 → 0x4000_0000…0.
  - 0x8000…0 × 1 → 0xFFFF…FFFF_8000…0.
- **Backpressure:** hold out_ready=0 for 20 cycles after out_valid → product stable and in_ready=0; a second in_valid pulse in that window is not captured. Release → in_ready=1 one cycle after the handshake edge.
- **Reset mid-op:** assert rst 4 cycles after accept → out_valid=0 and in_ready=1 once rst is low; a following 7×6 unsigned op returns 42.
- **Parameter sweep:** WIDTH=8 with PP_PER_CYCLE ∈ {1,2,8}, exhaustive 65536 pairs in both modes against a reference model. Latencies must be 9, 5 and 2 cycles.
- **Random regression:** 10k random 64-bit pairs, mixed modes, random out_ready, back-to-back in_valid → every result exact, no lost or duplicated transactions.
